rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the single combinational instruction ROM between the fetch stage (port F) and the data-side
//  load path (port D, constant/table reads from code space). Picks one requester per cycle, drives the
//  ROM word address, and returns registered read data one cycle after grant.
//  Sits between the CPU (IF stage / MEM stage) and ROM.
// PARAMETERS
//  ADDR_W     32  byte-address width of both requester ports
//  WORD_SHIFT 2   byte->word shift applied before driving rom_addr
//  ROM_WORDS  32  number of valid ROM words; indices >= this flag addr_err
//  MAX_WAIT   3   consecutive denied fetch cycles after which fetch is forced to win
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  f_req       in   1       fetch request
//  f_addr      in   ADDR_W  fetch byte address
//  f_gnt       out  1       fetch granted this cycle (combinational)
//  f_rvalid    out  1       fetch read data valid (registered)
//  d_req       in   1       data read request
//  d_addr      in   ADDR_W  data byte address
//  d_gnt       out  1       data granted this cycle (combinational)
//  d_rvalid    out  1       data read data valid (registered)
//  rdata       out  32      read data, shared; owner indicated by f_rvalid/d_rvalid
//  addr_err    out  1       qualifies rvalid: granted word index >= ROM_WORDS
//  rom_addr    out  32      word address to ROM = {WORD_SHIFT'b0, addr[ADDR_W-1:WORD_SHIFT]} of winner
//  rom_data    in   32      ROM combinational output
// BEHAVIOUR
//  - Reset (async): f_rvalid=d_rvalid=0, rdata=0, addr_err=0, starve_cnt=0, state=S_IDLE; stats cleared.
//    Reset mid-access drops the pending response; no rvalid after reset deassert until a new grant.
//  - Arbitration (combinational, same cycle): only one req -> it wins. Both req -> D wins unless
//    starve_cnt==MAX_WAIT, then F wins. No req -> no grant; rom_addr holds F address (F muxed by default).
//  - At most one of f_gnt/d_gnt high per cycle; gnt never asserted without the matching req.
//  - Response: at the posedge ending a grant cycle, rdata<=rom_data, addr_err<=(word index>=ROM_WORDS),
//    the granted port's rvalid<=1, other <=0. No grant -> both rvalid<=0, rdata and addr_err hold.
//    Latency fixed at 1 cycle; back-to-back grants give back-to-back rvalid; no backpressure on response.
//  - starve_cnt (width clog2(MAX_WAIT+1)): +1 when f_req && !f_gnt, saturating at MAX_WAIT;
//    cleared on f_gnt or when f_req low.
//  - FSM records last owner: S_IDLE (no grant), S_FETCH (F granted), S_DATA (D granted); next state = the
//    grant of the current cycle. A conflict is a cycle with f_req && d_req.
//  - Word index = addr[ADDR_W-1:WORD_SHIFT]; low WORD_SHIFT bits ignored (no alignment error).
// CONFIGURATION
//  ROM_ARB_STATS_EN defined: adds outputs stat_f_grants[15:0], stat_d_grants[15:0], stat_conflicts[15:0],
//   saturating at 16'hFFFF, incremented at posedge on f_gnt, d_gnt, conflict; cleared by reset only.
//  Not defined: these ports and counters do not exist; arbitration/timing identical.
// TESTING
//  1 reset high with f_req=1 -> no rvalid; release, f_addr=0x0 -> f_gnt same cycle; next cycle
//    f_rvalid=1, rdata=ROM word 0.
//  2 f_req only, f_addr 0x0,0x4,0x8 back-to-back -> f_rvalid on 3 consecutive cycles, rdata = words 0,1,2.
//  3 f_req=d_req=1 held, MAX_WAIT=3 -> grants D,D,D,F,D,D,D,F...; never both gnt.
//  4 d_req, d_addr=0x80 (index 32, ROM_WORDS=32) -> d_rvalid=1 with addr_err=1; d_addr=0x7C -> addr_err=0.
//  5 grant at cycle N, reset pulse between cycle-N posedge and next -> f_rvalid=d_rvalid=0, rdata=0 at once.
//  6 ROM_ARB_STATS_EN: 10 conflict cycles, MAX_WAIT=3 -> stat_conflicts=10, stat_f_grants=2,
//    stat_d_grants=8.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Arbitrates the shared instruction ROM between fetch (F) and data-side reads (D), with a 1-cycle registered response.
// Optional grant/conflict statistics counters are enabled with `define ROM_ARB_STATS_EN.
module rom_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_SHIFT = 2,
    parameter int unsigned ROM_WORDS  = 32,
    parameter int unsigned MAX_WAIT   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       rdata,
    output logic              addr_err,
    output logic [31:0]       rom_addr,
    input  logic [31:0]       rom_data
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_f_grants,
    output logic [15:0]       stat_d_grants,
    output logic [15:0]       stat_conflicts
`endif
);

    localparam int unsigned IDX_W = ADDR_W - WORD_SHIFT;
    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_WAIT);
    localparam logic [IDX_W-1:0] IDX_LIMIT  = IDX_W'(ROM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DATA
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_nxt;
    logic [ADDR_W-1:0] sel_addr;
    logic [IDX_W-1:0]  sel_idx;
    logic              unused_low_bits;

    // Arbitration, next owner and starvation count
    always_comb begin
        f_gnt      = 1'b0;
        d_gnt      = 1'b0;
        state_nxt  = S_IDLE;
        starve_nxt = '0;
        if (f_req && (!d_req || starve_cnt == STARVE_MAX)) begin
            f_gnt     = 1'b1;
            state_nxt = S_FETCH;
        end else if (d_req) begin
            d_gnt     = 1'b1;
            state_nxt = S_DATA;
        end
        if (f_req && !f_gnt) begin
            starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
        end
    end

    // F address is presented whenever D does not own the ROM, including idle cycles
    always_comb begin
        sel_addr        = d_gnt ? d_addr : f_addr;
        sel_idx         = sel_addr[ADDR_W-1:WORD_SHIFT];
        rom_addr        = 32'(sel_idx);
        unused_low_bits = ^sel_addr[WORD_SHIFT-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            rdata      <= '0;
            addr_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (f_gnt || d_gnt) begin
                rdata    <= rom_data;
                addr_err <= (sel_idx >= IDX_LIMIT);
            end
        end
    end

    // The registered owner of the previous cycle is exactly the response-valid indication
    assign f_rvalid = (state == S_FETCH);
    assign d_rvalid = (state == S_DATA);

`ifdef ROM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_f_grants  <= '0;
            stat_d_grants  <= '0;
            stat_conflicts <= '0;
        end else begin
            if (f_gnt && stat_f_grants != '1) begin
                stat_f_grants <= stat_f_grants + 16'd1;
            end
            if (d_gnt && stat_d_grants != '1) begin
                stat_d_grants <= stat_d_grants + 16'd1;
            end
            if (f_req && d_req && stat_conflicts != '1) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: expected grants/responses are predicted when stimulus is driven.
module tb_rom_port_arbiter;

    localparam int unsigned MAX_WAIT  = 3;
    localparam int unsigned ROM_WORDS = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        f_req = 1'b0;
    logic        d_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic [31:0] d_addr = '0;
    logic        f_gnt, d_gnt, f_rvalid, d_rvalid, addr_err;
    logic [31:0] rdata, rom_addr, rom_data;
`ifdef ROM_ARB_STATS_EN
    logic [15:0] stat_f_grants, stat_d_grants, stat_conflicts;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        f;
        logic        d;
        logic [31:0] data;
        logic        err;
    } resp_t;
    resp_t sb[$];

    int unsigned m_starve = 0;
    logic [31:0] m_data   = '0;
    logic        m_err    = 1'b0;
    logic        exp_f, exp_d;

    function automatic logic [31:0] rom_fn(input logic [31:0] w);
        return {w[15:0] ^ 16'h5A5A, ~w[15:0]};
    endfunction

    assign rom_data = rom_fn(rom_addr);

    always #5 clk = ~clk;

    rom_port_arbiter #(
        .ADDR_W    (32),
        .WORD_SHIFT(2),
        .ROM_WORDS (ROM_WORDS),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .rdata    (rdata),
        .addr_err (addr_err),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
`ifdef ROM_ARB_STATS_EN
        ,
        .stat_f_grants (stat_f_grants),
        .stat_d_grants (stat_d_grants),
        .stat_conflicts(stat_conflicts)
`endif
    );

    task automatic model_reset();
        m_starve = 0;
        m_data   = '0;
        m_err    = 1'b0;
        sb.delete();
    endtask

    // Reference arbitration: predicts grants for this cycle and pushes the response due next cycle
    task automatic predict(input logic fr, input logic [31:0] fa, input logic dr, input logic [31:0] da);
        logic [31:0] a;
        exp_f = fr && (!dr || m_starve == MAX_WAIT);
        exp_d = dr && !exp_f;
        if (exp_f || exp_d) begin
            a      = exp_d ? da : fa;
            m_data = rom_fn(a >> 2);
            m_err  = ((a >> 2) >= ROM_WORDS);
        end
        sb.push_back('{exp_f, exp_d, m_data, m_err});
        if (fr && !exp_f) m_starve = (m_starve == MAX_WAIT) ? m_starve : m_starve + 1;
        else              m_starve = 0;
    endtask

    task automatic run_cycle(input logic fr, input logic [31:0] fa, input logic dr, input logic [31:0] da,
                             output logic gf, output logic gd, output logic [31:0] ra);
        f_req  = fr;
        f_addr = fa;
        d_req  = dr;
        d_addr = da;
        predict(fr, fa, dr, da);
        @(negedge clk);
        gf = f_gnt;
        gd = d_gnt;
        ra = rom_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({f_rvalid, d_rvalid, addr_err, rdata} !== 35'b0) begin
                errors++;
                $display("FAIL reset_hold: got fv=%b dv=%b err=%b rdata=%h, want all zero",
                         f_rvalid, d_rvalid, addr_err, rdata);
            end
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_fetch();
        logic gf, gd;
        logic [31:0] ra;
        resp_t e;
        run_cycle(1'b1, 32'h0, 1'b0, 32'h0, gf, gd, ra);
        checks++;
        if ({gf, gd} !== {exp_f, exp_d}) begin
            errors++;
            $display("FAIL first_gnt: got f_gnt=%b d_gnt=%b, want %b %b", gf, gd, exp_f, exp_d);
        end
        e = sb.pop_front();
        checks++;
        if ({f_rvalid, d_rvalid} !== {e.f, e.d} || rdata !== e.data || addr_err !== e.err) begin
            errors++;
            $display("FAIL first_resp: got fv=%b dv=%b data=%h err=%b, want %b %b %h %b",
                     f_rvalid, d_rvalid, rdata, addr_err, e.f, e.d, e.data, e.err);
        end
    endtask

    task automatic test_back_to_back();
        logic gf, gd;
        logic [31:0] ra;
        logic [31:0] fa [4] = '{32'h0, 32'h4, 32'h8, 32'h20};
        logic        fr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ra_exp [4] = '{32'd0, 32'd1, 32'd2, 32'd8};
        resp_t e;
        for (int i = 0; i < 4; i++) begin
            run_cycle(fr[i], fa[i], 1'b0, 32'h44, gf, gd, ra);
            checks++;
            if ({gf, gd} !== {exp_f, exp_d} || ra !== ra_exp[i]) begin
                errors++;
                $display("FAIL b2b_gnt[%0d]: got gnt=%b%b rom_addr=%h, want %b%b %h",
                         i, gf, gd, ra, exp_f, exp_d, ra_exp[i]);
            end
            e = sb.pop_front();
            checks++;
            if ({f_rvalid, d_rvalid} !== {e.f, e.d} || rdata !== e.data || addr_err !== e.err) begin
                errors++;
                $display("FAIL b2b_resp[%0d]: got fv=%b dv=%b data=%h err=%b, want %b %b %h %b",
                         i, f_rvalid, d_rvalid, rdata, addr_err, e.f, e.d, e.data, e.err);
            end
        end
    endtask

    task automatic test_conflict();
        logic gf, gd;
        logic [31:0] ra;
        resp_t e;
        // 8 held conflicts, then 2 conflicts, one D-only cycle (clears starvation), 4 conflicts
        logic fr [15] = '{1,1,1,1,1,1,1,1, 1,1, 0, 1,1,1,1};
        for (int i = 0; i < 15; i++) begin
            run_cycle(fr[i], 32'h10 + 32'(i * 4), 1'b1, 32'h40 + 32'(i * 4), gf, gd, ra);
            checks++;
            if ({gf, gd} !== {exp_f, exp_d}) begin
                errors++;
                $display("FAIL conflict_gnt[%0d]: got f_gnt=%b d_gnt=%b, want %b %b", i, gf, gd, exp_f, exp_d);
            end
            e = sb.pop_front();
            checks++;
            if ({f_rvalid, d_rvalid} !== {e.f, e.d} || rdata !== e.data || addr_err !== e.err) begin
                errors++;
                $display("FAIL conflict_resp[%0d]: got fv=%b dv=%b data=%h err=%b, want %b %b %h %b",
                         i, f_rvalid, d_rvalid, rdata, addr_err, e.f, e.d, e.data, e.err);
            end
        end
    endtask

    task automatic test_addr_err();
        logic gf, gd;
        logic [31:0] ra;
        resp_t e;
        logic        fr [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        dr [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] fa [4] = '{32'h0, 32'h0, 32'h83, 32'h0};
        logic [31:0] da [4] = '{32'h80, 32'h7C, 32'h0, 32'h80};
        for (int i = 0; i < 4; i++) begin
            run_cycle(fr[i], fa[i], dr[i], da[i], gf, gd, ra);
            e = sb.pop_front();
            checks++;
            if ({f_rvalid, d_rvalid} !== {e.f, e.d} || rdata !== e.data || addr_err !== e.err) begin
                errors++;
                $display("FAIL addr_err[%0d]: got fv=%b dv=%b data=%h err=%b, want %b %b %h %b",
                         i, f_rvalid, d_rvalid, rdata, addr_err, e.f, e.d, e.data, e.err);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic gf, gd;
        logic [31:0] ra;
        resp_t e;
        run_cycle(1'b1, 32'h14, 1'b0, 32'h0, gf, gd, ra);
        e = sb.pop_front();
        checks++;
        if (f_rvalid !== 1'b1 || rdata !== e.data) begin
            errors++;
            $display("FAIL midreset_pre: got fv=%b data=%h, want 1 %h", f_rvalid, rdata, e.data);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({f_rvalid, d_rvalid, addr_err, rdata} !== 35'b0) begin
            errors++;
            $display("FAIL midreset_async: got fv=%b dv=%b err=%b rdata=%h, want all zero",
                     f_rvalid, d_rvalid, addr_err, rdata);
        end
        reset = 1'b0;
        model_reset();
        run_cycle(1'b0, 32'h14, 1'b0, 32'h0, gf, gd, ra);
        e = sb.pop_front();
        checks++;
        if ({f_rvalid, d_rvalid} !== {e.f, e.d} || rdata !== e.data || addr_err !== e.err) begin
            errors++;
            $display("FAIL midreset_post: got fv=%b dv=%b data=%h err=%b, want %b %b %h %b",
                     f_rvalid, d_rvalid, rdata, addr_err, e.f, e.d, e.data, e.err);
        end
    endtask

`ifdef ROM_ARB_STATS_EN
    task automatic test_stats();
        logic gf, gd;
        logic [31:0] ra;
        resp_t e;
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b1, 32'h8, 1'b1, 32'hC, gf, gd, ra);
            e = sb.pop_front();
        end
        checks++;
        if (stat_conflicts !== 16'd10 || stat_f_grants !== 16'd2 || stat_d_grants !== 16'd8) begin
            errors++;
            $display("FAIL stats: got conflicts=%0d f=%0d d=%0d, want 10 2 8",
                     stat_conflicts, stat_f_grants, stat_d_grants);
        end
    endtask
`endif

    initial begin
        f_req  = 1'b1;
        f_addr = 32'h0;
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_conflict();
        test_addr_err();
        test_reset_mid();
`ifdef ROM_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
